mvau_stream_ctrl_pp: RTL and testbench

Next-generation control unit for the MVAU streaming block. It generalises the single-buffer input control to a ping-pong (two-bank) input buffer: the next activation vector is written while the current one is re-read NF times. SF and NF are runtime-configurable up to compile-time maxima, and output back-pressure stalls computation. It sits between the input activation stream, the weight stream, the input buffer RAM and the PE/SIMD datapath inside `mvau_stream`.

---
 rtl/mvau_stream_pkg.sv | 29 ++
 rtl/mvau_stream_ib_wr_ctrl.sv | 56 +++++
 rtl/mvau_stream_ctrl_pp.sv | 161 ++++++++++++++++
 tb/tb_mvau_stream_ctrl_pp.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/mvau_stream_pkg.sv
// Shared types and helpers for the MVAU stream control blocks.
package mvau_stream_pkg;

  // Read-side FSM: wait for a full bank, then stream it NF times.
  typedef enum logic {
    R_WAIT = 1'b0,
    R_RUN  = 1'b1
  } rd_state_t;

  // One register stage between buffer read and accumulate.
  localparam int ACC_STAGES = 1;

  // Row-position flags that travel with a read beat into the acc stage.
  typedef struct packed {
    logic clr;
    logic last;
  } acc_flags_t;

  // Counter width for a depth of n, never below one bit.
  function automatic int cnt_w(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // A beat is the bank's final one when both sf and nf sit at their max.
  function automatic logic last_beat(input logic sf_at_max, input logic nf_at_max);
    return sf_at_max & nf_at_max;
  endfunction

endpackage

// File: rtl/mvau_stream_ib_wr_ctrl.sv
// Write side of the ping-pong input buffer: address counter, bank select, ready.
module mvau_stream_ib_wr_ctrl
  import mvau_stream_pkg::*;
#(
  parameter int SF_T = 3
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic [SF_T-1:0] sf_m1,
  input  logic [1:0]      bank_full,
  input  logic            in_v,
  output logic            in_rdy,
  output logic            ib_wen,
  output logic            ib_wbank,
  output logic [SF_T-1:0] ib_waddr,
  output logic [1:0]      bank_set
);

  logic            rst_done_q, rst_done_d;
  logic            wbank_q, wbank_d;
  logic [SF_T-1:0] wr_sf_q, wr_sf_d;
  logic            wr_beat, wr_wrap;

  // Accept while the bank being filled is free; a wrap marks it full and flips banks.
  always_comb begin
    in_rdy     = rst_done_q & ~bank_full[wbank_q];
    wr_beat    = in_v & in_rdy;
    wr_wrap    = wr_beat & (wr_sf_q == sf_m1);
    rst_done_d = 1'b1;
    wr_sf_d    = wr_sf_q;
    wbank_d    = wbank_q;
    bank_set   = '0;
    if (wr_beat) wr_sf_d = wr_wrap ? '0 : wr_sf_q + 1'b1;
    if (wr_wrap) begin
      wbank_d            = ~wbank_q;
      bank_set[wbank_q]  = 1'b1;
    end
    ib_wen   = wr_beat;
    ib_wbank = wbank_q;
    ib_waddr = wr_sf_q;
  end

  // Write-side state; rst_done holds in_rdy low until the first edge after reset.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rst_done_q <= 1'b0;
      wbank_q    <= 1'b0;
      wr_sf_q    <= '0;
    end else begin
      rst_done_q <= rst_done_d;
      wbank_q    <= wbank_d;
      wr_sf_q    <= wr_sf_d;
    end
  end

endmodule

// File: rtl/mvau_stream_ctrl_pp.sv
// Ping-pong input buffer control for the MVAU stream: bank flags, read FSM,
// accumulate pipeline and output register.
module mvau_stream_ctrl_pp
  import mvau_stream_pkg::*;
#(
  parameter int SF_MAX = 8,
  parameter int NF_MAX = 4,
  parameter int SF_T   = cnt_w(SF_MAX),
  parameter int NF_T   = cnt_w(NF_MAX)
) (
  input  logic            aclk,
  input  logic            aresetn,
  input  logic [SF_T-1:0] cfg_sf_m1,
  input  logic [NF_T-1:0] cfg_nf_m1,
  input  logic            in_v,
  output logic            in_rdy,
  input  logic            wmem_v,
  output logic            wmem_rdy,
  input  logic            out_rdy,
  output logic            out_v,
  output logic            ib_wen,
  output logic            ib_wbank,
  output logic [SF_T-1:0] ib_waddr,
  output logic            ib_ren,
  output logic            ib_rbank,
  output logic [SF_T-1:0] ib_raddr,
  output logic            acc_en,
  output logic            acc_clr,
  output logic            acc_last,
  output logic [NF_T-1:0] nf_cnt,
  output logic            busy
);

  rd_state_t           rd_state_q, rd_state_d;
  logic [SF_T-1:0]     sf_m1_q, sf_m1_d, sf_m1_eff, rd_sf_q, rd_sf_d;
  logic [NF_T-1:0]     nf_m1_q, nf_m1_d, nf_q, nf_d;
  logic [1:0]          bank_full_q, bank_full_d, bank_set, bank_clr;
  logic                rbank_q, rbank_d, out_v_q, out_v_d;
  logic [ACC_STAGES:1] vld_pipe_q, vld_pipe_d;
  logic [ACC_STAGES:0] vld_pipe;
  acc_flags_t          acc_q, acc_d;
  logic                cfg_latch, sf_at_max, nf_at_max, blk, rd_beat, rd_final;

  // The write side sees the incoming config in the latching cycle so the
  // first word of a fresh vector already wraps at the new SF.
  mvau_stream_ib_wr_ctrl #(.SF_T(SF_T)) u_wr (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .sf_m1     (sf_m1_eff),
    .bank_full (bank_full_q),
    .in_v      (in_v),
    .in_rdy    (in_rdy),
    .ib_wen    (ib_wen),
    .ib_wbank  (ib_wbank),
    .ib_waddr  (ib_waddr),
    .bank_set  (bank_set)
  );

  assign vld_pipe = {vld_pipe_q, rd_beat};

  // Config latch, stall rules, counters, bank flags and acc/output next state.
  always_comb begin
    busy      = (|bank_full_q) | vld_pipe_q[ACC_STAGES];
    cfg_latch = ~busy & (ib_waddr == '0);
    sf_m1_eff = cfg_latch ? cfg_sf_m1 : sf_m1_q;
    sf_m1_d   = sf_m1_eff;
    nf_m1_d   = cfg_latch ? cfg_nf_m1 : nf_m1_q;

    sf_at_max = (rd_sf_q == sf_m1_q);
    nf_at_max = (nf_q == nf_m1_q);
    // A last-of-row beat must not land behind another one still in the acc
    // stage, or it would overwrite a result the output register cannot hold.
    blk       = (out_v_q & ~out_rdy) |
                (sf_at_max & vld_pipe_q[ACC_STAGES] & acc_q.last);
    rd_final  = rd_beat & last_beat(sf_at_max, nf_at_max);

    rd_sf_d = rd_sf_q;
    nf_d    = nf_q;
    if (rd_beat) begin
      if (sf_at_max) begin
        rd_sf_d = '0;
        nf_d    = nf_at_max ? '0 : nf_q + 1'b1;
      end else begin
        rd_sf_d = rd_sf_q + 1'b1;
      end
    end

    bank_clr = '0;
    if (rd_final) bank_clr[rbank_q] = 1'b1;
    bank_full_d = (bank_full_q | bank_set) & ~bank_clr;
    rbank_d     = rbank_q ^ rd_final;

    vld_pipe_d = vld_pipe[ACC_STAGES-1:0];
    acc_d.clr  = rd_beat & (rd_sf_q == '0);
    acc_d.last = rd_beat & sf_at_max;

    out_v_d = out_v_q;
    if (vld_pipe_q[ACC_STAGES] & acc_q.last) out_v_d = 1'b1;
    else if (out_v_q & out_rdy)              out_v_d = 1'b0;
  end

  // Read FSM next state; a bank being set this cycle counts as full.
  always_comb begin
    rd_state_d = rd_state_q;
    case (rd_state_q)
      R_WAIT:  if (bank_full_d[rbank_q]) rd_state_d = R_RUN;
      R_RUN:   if (rd_final && !bank_full_d[~rbank_q]) rd_state_d = R_WAIT;
      default: rd_state_d = R_WAIT;
    endcase
  end

  // Read FSM outputs: a beat consumes one weight word and reads one buffer word.
  always_comb begin
    rd_beat = 1'b0;
    case (rd_state_q)
      R_RUN:   rd_beat = wmem_v & ~blk;
      default: rd_beat = 1'b0;
    endcase
    ib_ren   = rd_beat;
    wmem_rdy = rd_beat;
    ib_rbank = rbank_q;
    ib_raddr = rd_sf_q;
    nf_cnt   = nf_q;
    acc_en   = vld_pipe_q[ACC_STAGES];
    acc_clr  = acc_q.clr;
    acc_last = acc_q.last;
    out_v    = out_v_q;
  end

  // Read FSM state register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) rd_state_q <= R_WAIT;
    else          rd_state_q <= rd_state_d;
  end

  // Config, counters, bank flags, acc pipeline and output register.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      sf_m1_q     <= '0;
      nf_m1_q     <= '0;
      rd_sf_q     <= '0;
      nf_q        <= '0;
      bank_full_q <= '0;
      rbank_q     <= 1'b0;
      vld_pipe_q  <= '0;
      acc_q       <= '0;
      out_v_q     <= 1'b0;
    end else begin
      sf_m1_q     <= sf_m1_d;
      nf_m1_q     <= nf_m1_d;
      rd_sf_q     <= rd_sf_d;
      nf_q        <= nf_d;
      bank_full_q <= bank_full_d;
      rbank_q     <= rbank_d;
      vld_pipe_q  <= vld_pipe_d;
      acc_q       <= acc_d;
      out_v_q     <= out_v_d;
    end
  end

endmodule

// File: tb/tb_mvau_stream_ctrl_pp.sv
// Randomized bench for mvau_stream_ctrl_pp against a vector/beat-count model.
module tb_mvau_stream_ctrl_pp;

  localparam int SF_T = 3;
  localparam int NF_T = 2;

  logic            aclk = 1'b0;
  logic            aresetn = 1'b0;
  logic [SF_T-1:0] cfg_sf_m1 = '0;
  logic [NF_T-1:0] cfg_nf_m1 = '0;
  logic            in_v = 1'b0, wmem_v = 1'b0, out_rdy = 1'b0;
  logic            in_rdy, wmem_rdy, out_v, ib_wen, ib_wbank, ib_ren, ib_rbank;
  logic            acc_en, acc_clr, acc_last, busy;
  logic [SF_T-1:0] ib_waddr, ib_raddr;
  logic [NF_T-1:0] nf_cnt;

  mvau_stream_ctrl_pp #(.SF_MAX(8), .NF_MAX(4)) dut (
    .aclk(aclk), .aresetn(aresetn), .cfg_sf_m1(cfg_sf_m1), .cfg_nf_m1(cfg_nf_m1),
    .in_v(in_v), .in_rdy(in_rdy), .wmem_v(wmem_v), .wmem_rdy(wmem_rdy),
    .out_rdy(out_rdy), .out_v(out_v), .ib_wen(ib_wen), .ib_wbank(ib_wbank),
    .ib_waddr(ib_waddr), .ib_ren(ib_ren), .ib_rbank(ib_rbank), .ib_raddr(ib_raddr),
    .acc_en(acc_en), .acc_clr(acc_clr), .acc_last(acc_last), .nf_cnt(nf_cnt),
    .busy(busy)
  );

  always #5 aclk = ~aclk;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0d exp %0d @%0t", tag, got, exp, $time);
    end
  endtask

  // Model: vectors written vs. vectors consumed, beat index within the bank.
  int m_sf, m_nf, wr_cnt, w_vec, r_vec, r_beat, m_words;
  bit m_rst_done, acc_v, acc_clr_p, acc_last_p, m_outv;
  bit e_in_rdy, e_wr, e_ren, e_busy;
  int e_rsf, e_nfi;
  int c_ren, c_rows, c_out, c_wr;

  task automatic model_reset();
    m_sf = 1; m_nf = 1; wr_cnt = 0; w_vec = 0; r_vec = 0; r_beat = 0;
    m_rst_done = 0; acc_v = 0; acc_clr_p = 0; acc_last_p = 0; m_outv = 0;
  endtask

  task automatic model_comb();
    e_busy = (w_vec != r_vec) || acc_v;
    if (!e_busy && wr_cnt == 0) begin
      m_sf = int'(cfg_sf_m1) + 1;
      m_nf = int'(cfg_nf_m1) + 1;
    end
    e_rsf    = r_beat % m_sf;
    e_nfi    = r_beat / m_sf;
    e_in_rdy = m_rst_done && (w_vec - r_vec < 2);
    e_wr     = in_v && e_in_rdy;
    e_ren    = (w_vec != r_vec) && wmem_v &&
               !((m_outv && !out_rdy) || (e_rsf == m_sf - 1 && acc_v && acc_last_p));
  endtask

  task automatic model_seq();
    if (e_wr) begin
      m_words++;
      wr_cnt++;
      if (wr_cnt == m_sf) begin wr_cnt = 0; w_vec++; end
    end
    if (acc_v && acc_last_p) m_outv = 1;
    else if (m_outv && out_rdy) m_outv = 0;
    acc_v      = e_ren;
    acc_clr_p  = e_ren && (e_rsf == 0);
    acc_last_p = e_ren && (e_rsf == m_sf - 1);
    if (e_ren) begin
      if (r_beat == m_sf * m_nf - 1) begin r_beat = 0; r_vec++; end
      else r_beat++;
    end
    m_rst_done = 1;
  endtask

  task automatic check_all();
    chk("in_rdy",   in_rdy,   e_in_rdy);
    chk("ib_wen",   ib_wen,   e_wr);
    chk("ib_waddr", ib_waddr, wr_cnt);
    chk("ib_wbank", ib_wbank, w_vec % 2);
    chk("ib_ren",   ib_ren,   e_ren);
    chk("wmem_rdy", wmem_rdy, e_ren);
    chk("ib_raddr", ib_raddr, e_rsf);
    chk("ib_rbank", ib_rbank, r_vec % 2);
    chk("nf_cnt",   nf_cnt,   e_nfi);
    chk("acc_en",   acc_en,   acc_v);
    chk("acc_clr",  acc_clr,  acc_v && acc_clr_p);
    chk("acc_last", acc_last, acc_v && acc_last_p);
    chk("out_v",    out_v,    m_outv);
    chk("busy",     busy,     e_busy);
  endtask

  // One cycle: inputs already driven at the falling edge.
  task automatic step();
    #1;
    model_comb();
    check_all();
    if (ib_ren) c_ren++;
    if (acc_en && acc_last) c_rows++;
    if (out_v && out_rdy) c_out++;
    if (ib_wen) c_wr++;
    @(posedge aclk);
    model_seq();
    @(negedge aclk);
  endtask

  task automatic run_phase(input int sfm1, input int nfm1, input int nwords, input int ncyc,
                           input int p_in, input int p_wm, input int p_or,
                           input int lo_s, input int lo_n, input bit churn);
    c_ren = 0; c_rows = 0; c_out = 0; c_wr = 0; m_words = 0;
    for (int c = 0; c < ncyc; c++) begin
      if (churn) begin
        if ($urandom_range(0, 99) < 5) begin
          cfg_sf_m1 = SF_T'($urandom_range(0, 7));
          cfg_nf_m1 = NF_T'($urandom_range(0, 3));
        end
      end else begin
        cfg_sf_m1 = SF_T'(sfm1);
        cfg_nf_m1 = NF_T'(nfm1);
      end
      in_v    = (m_words < nwords) && ($urandom_range(0, 99) < p_in);
      wmem_v  = ($urandom_range(0, 99) < p_wm);
      out_rdy = (c >= lo_s && c < lo_s + lo_n) ? 1'b0 : ($urandom_range(0, 99) < p_or);
      step();
    end
  endtask

  // Asynchronous reset asserted between edges; outputs must clear at once.
  task automatic rst_pulse(input int sfm1, input int nfm1);
    #2;
    aresetn = 1'b0;
    in_v = 1'b0; wmem_v = 1'b0; out_rdy = 1'b0;
    cfg_sf_m1 = SF_T'(sfm1);
    cfg_nf_m1 = NF_T'(nfm1);
    #1;
    chk("rst_in_rdy", in_rdy, 0);
    chk("rst_ib_ren", ib_ren, 0);
    chk("rst_wmem_rdy", wmem_rdy, 0);
    chk("rst_acc_en", acc_en, 0);
    chk("rst_acc_flags", {acc_clr, acc_last}, 0);
    chk("rst_out_v", out_v, 0);
    chk("rst_busy", busy, 0);
    chk("rst_addrs", {ib_waddr, ib_raddr, nf_cnt, ib_wbank, ib_rbank}, 0);
    model_reset();
    @(posedge aclk);
    @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout n_chk %0d", n_chk);
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    @(negedge aclk);

    // SF=4 NF=1, three vectors, everything always ready.
    rst_pulse(3, 0);
    run_phase(3, 0, 12, 40, 100, 100, 100, 0, 0, 0);
    chk("A_ren", c_ren, 12);
    chk("A_rows", c_rows, 3);
    chk("A_outs", c_out, 3);

    // SF=4 NF=3, two vectors back to back.
    rst_pulse(3, 2);
    run_phase(3, 2, 8, 45, 100, 100, 100, 0, 0, 0);
    chk("B_ren", c_ren, 24);
    chk("B_rows", c_rows, 6);
    chk("B_wr", c_wr, 8);

    // SF=2 NF=4, no weights: both banks fill, nothing is read.
    rst_pulse(1, 3);
    run_phase(1, 3, 100, 40, 100, 0, 100, 0, 0, 0);
    chk("C_ren", c_ren, 0);
    chk("C_wr", c_wr, 4);
    chk("C_in_rdy_end", in_rdy, 0);

    // SF=1 NF=2, downstream stalled for the first 5 cycles.
    rst_pulse(0, 1);
    run_phase(0, 1, 1, 20, 100, 100, 100, 0, 5, 0);
    chk("D_ren", c_ren, 2);
    chk("D_outs", c_out, 2);

    // SF changed mid-vector: old SF finishes the vector, new SF applies after idle.
    rst_pulse(3, 0);
    run_phase(3, 0, 2, 3, 100, 100, 100, 0, 0, 0);
    run_phase(1, 0, 2, 30, 100, 100, 100, 0, 0, 0);
    chk("E_old_ren", c_ren, 4);
    chk("E_old_rows", c_rows, 1);
    run_phase(1, 0, 4, 30, 100, 100, 100, 0, 0, 0);
    chk("E_new_ren", c_ren, 4);
    chk("E_new_rows", c_rows, 2);

    // Max config with random handshakes.
    rst_pulse(7, 3);
    run_phase(7, 3, 100000, 400, 70, 70, 70, 0, 0, 0);

    // Random config churn.
    rst_pulse(0, 0);
    run_phase(0, 0, 100000, 600, 80, 60, 60, 0, 0, 1);

    // Reset mid-row while the output register holds a result.
    rst_pulse(2, 1);
    run_phase(2, 1, 100, 10, 100, 100, 0, 0, 0, 0);
    chk("F_outv_before_rst", out_v, 1);
    rst_pulse(2, 1);
    run_phase(2, 1, 100000, 80, 90, 90, 90, 0, 0, 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
